// File: rtl/sram_64kb.sv
// Single-port 16K x 32 global buffer with per-byte write lanes and a registered,
// read-first output. Contents are left uninitialised so a hex preload can fill `memory`.
module sram_64kb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W/8-1:0]   WEB,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     write_data,
  output logic [DATA_W-1:0]     read_data
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] memory [0:DEPTH-1];
  logic [DATA_W-1:0] read_data_reg;

  // Byte-lane write port; the array is deliberately never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        if (WEB[i]) begin
          memory[addr][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  // Read-first: this samples the word as it was before the same edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_reg <= '0;
    end else begin
      read_data_reg <= memory[addr];
    end
  end

  assign read_data = read_data_reg;

endmodule

// File: tb/tb_sram_64kb.sv
// Directed bench for sram_64kb: a word/byte-level reference memory predicts every read,
// and literal expectations pin the key scenarios, including async reset mid-stream.
module tb_sram_64kb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  WEB;
  logic [13:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int vectors;
  int miscompares;

  logic [31:0] mdl [0:16383];
  bit   [3:0]  known [0:16383];

  sram_64kb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .WEB        (WEB),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s addr=%h got=%h want=%h t=%0t", name, addr, act, exp, $time);
    end
  endtask

  // Called with clk low; applies one access across the next rising edge and checks on the falling edge.
  task automatic step(input logic [3:0] we, input logic [13:0] a, input logic [31:0] d,
                      input logic [31:0] lit, input bit use_lit);
    logic [31:0] exp;
    bit          chk;
    WEB        = we;
    addr       = a;
    write_data = d;
    exp = mdl[a];
    chk = (known[a] == 4'hF);
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mdl[a][8*i +: 8] = d[8*i +: 8];
          known[a][i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (!rst_n) check("reset_hold", read_data, 32'h0);
    else if (chk) check("model", read_data, exp);
    if (use_lit) check("literal", read_data, lit);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 16384; i++) known[i] = 4'h0;
    rst_n      = 1'b0;
    WEB        = 4'h0;
    addr       = '0;
    write_data = '0;

    repeat (2) @(negedge clk);
    check("reset_value", read_data, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Load the words the scenarios rely on.
    step(4'hF, 14'd0, 32'h0000_1111, 32'h0, 1'b0);
    step(4'hF, 14'd1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    step(4'hF, 14'd5, 32'h1122_3344, 32'h0, 1'b0);
    step(4'hF, 14'd7, 32'h0000_0007, 32'h0, 1'b0);

    step(4'h0, 14'd0, 32'h0, 32'h0000_1111, 1'b1);
    step(4'h0, 14'd1, 32'h0, 32'hDEAD_BEEF, 1'b1);

    // Byte-masked write: old value returned during the write, merged value afterwards.
    step(4'b0011, 14'd5, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
    step(4'h0,    14'd5, 32'h0,         32'h1122_CCDD, 1'b1);

    // Read-during-write returns the pre-write contents.
    step(4'hF, 14'd7, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1);
    step(4'h0, 14'd7, 32'h0,         32'hFFFF_FFFF, 1'b1);

    // Extreme addresses must not alias each other.
    step(4'hF, 14'h3FFF, 32'h5A5A_A5A5, 32'h0, 1'b0);
    step(4'hF, 14'h0000, 32'h1234_5678, 32'h0000_1111, 1'b1);
    step(4'h0, 14'h3FFF, 32'h0, 32'h5A5A_A5A5, 1'b1);
    step(4'h0, 14'h0000, 32'h0, 32'h1234_5678, 1'b1);
    step(4'h0, 14'd1,    32'h0, 32'hDEAD_BEEF, 1'b1);

    // Back-to-back full writes, partial overwrites, then reads, all against the model.
    for (int i = 0; i < 24; i++)
      step(4'hF, 14'((i * 517 + 9) & 16'h3FFF), 32'h0101_0101 * i ^ 32'hC3A5_5A3C, 32'h0, 1'b0);
    for (int i = 0; i < 24; i++)
      step(4'(i % 16), 14'((i * 517 + 9) & 16'h3FFF), 32'h9E37_79B9 * (i + 1), 32'h0, 1'b0);
    for (int i = 23; i >= 0; i--)
      step(4'h0, 14'((i * 517 + 9) & 16'h3FFF), 32'h0, 32'h0, 1'b0);

    // Async reset between edges: output clears at once, writes are blocked, contents survive.
    step(4'h0, 14'd1, 32'h0, 32'hDEAD_BEEF, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", read_data, 32'h0);
    @(negedge clk);
    step(4'hF, 14'd1, 32'h0BAD_0BAD, 32'h0, 1'b1);
    step(4'hF, 14'd5, 32'h0000_0000, 32'h0, 1'b1);
    #2 rst_n = 1'b1;
    step(4'h0, 14'd1, 32'h0, 32'hDEAD_BEEF, 1'b1);
    step(4'h0, 14'd5, 32'h0, 32'h1122_CCDD, 1'b1);
    step(4'h0, 14'd0, 32'h0, 32'h1234_5678, 1'b1);
    step(4'h0, 14'd7, 32'h0, 32'hFFFF_FFFF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_64kb.md
# sram_64kb

Single-port 64 KB on-chip buffer (global buffer, GLB) organised as 16384 words × 32 bits, with per-byte write enables and a registered read port. It sits beside the token engine / conv unit pair. It supplies weights, ifmap, ipsum and bias words addressed by byte-address bits [15:2], and accepts opsum writes. Contents are preloadable from a hex file through the hierarchical array `memory`.

## Interface
Parameters:
- `ADDR_W`, default 14: word-address width; depth = 2^ADDR_W = 16384.
- `DATA_W`, default 32: word width; must be a multiple of 8; byte lanes = DATA_W/8 = 4.

Ports:
- `clk`  in  1  : single clock; all state changes on the rising edge.
- `rst_n`  in  1  : reset, asynchronous and active-low.
- `WEB`  in  4 (DATA_W/8)  : per-byte write enable, active-high; bit i = 1 writes byte lane i; 4'b0000 = read-only cycle.
- `addr`  in  14 (ADDR_W)  : word address; the caller drives byte-address bits [15:2].
- `write_data`  in  32  : write data; lane i = bits [8i+7:8i].
- `read_data`  out  32  : registered read data.

Storage:
- Internal array named exactly `memory`.
- Declared as [0:16383] of 32-bit words.
- Must be accessible as `<inst>.memory` for `$readmemh`. Word 0 = first hex entry.

## Operation
- Port is always enabled; there is no chip-select. A read of `memory[addr]` occurs on every rising edge.
- Write: on a rising edge, for each lane i with `WEB[i]` = 1, set `memory[addr][8i+7:8i]` = `write_data[8i+7:8i]`. Lanes with `WEB[i]` = 0 keep their value.
- Read: on each rising edge, `read_data` is loaded with `memory[addr]`.
- Read-during-write is read-first: `read_data` gets the contents before that edge's write. The new bytes are visible on the following access.
- Reset clears only `read_data`. `memory` contents are never reset or initialised by RTL.
- Addresses span the full 0..16383 range, so no out-of-range case exists. There is no wrap logic beyond natural ADDR_W truncation.
- Uninitialised words read as X in simulation. No other X handling is required.

## Timing
- Reset value: `read_data` = 32'h0000_0000 immediately on `rst_n` falling edge, independent of `clk`. It is held while `rst_n` = 0.
- Writes are suppressed while `rst_n` = 0. Reset asserted mid-operation aborts any write on that edge, and `memory` is unchanged.
- Read latency is 1 cycle: `addr` sampled at edge N gives `read_data` valid after edge N, stable until edge N+1.
- Write latency is 1 cycle: data written at edge N is readable by an `addr` sampled at edge N+1, appearing on `read_data` after edge N+1.
- Back-to-back accesses to different addresses are allowed every cycle with no bubbles.
- The first edge after `rst_n` rises performs a normal access.

## Test plan
- Preload: `$readmemh` a file with word 0 = 32'h0000_1111 and word 1 = 32'hDEAD_BEEF, release reset, `addr` = 0 then 1, `WEB` = 0. Expected: `read_data` = 32'h0000_1111 then 32'hDEAD_BEEF, each one cycle after its address.
- Byte-masked write: word 5 = 32'h1122_3344; write `WEB` = 4'b0011 with `write_data` = 32'hAABB_CCDD; then read 5. Expected: 32'h1122_CCDD.
- Read-during-write: word 7 = 32'h0000_0007; write `WEB` = 4'b1111 with data 32'hFFFF_FFFF at `addr` 7. Expected: same-cycle `read_data` = 32'h0000_0007; next read of 7 returns 32'hFFFF_FFFF.
- Boundary addresses: write 32'h5A5A_A5A5 to `addr` = 14'h3FFF and 32'h1234_5678 to `addr` = 0, then read both. Expected: each returns its own value, with no aliasing.
- Async reset mid-stream: while reading a nonzero word, drop `rst_n` between edges. Expected: `read_data` goes to 0 without a clock edge; a write attempted during reset leaves the word unchanged; preloaded data is still intact after reset.
